eq_queue_seq_ctrl: RTL and testbench



---
 rtl/eq_queue_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_eq_queue_seq_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/eq_queue_seq_ctrl.sv
// Write/read pointer and FIR pass sequencing for one band's circular sample queue.
// Define RD_LAT2_EN for registered-output RAMs (two-cycle read latency).
module eq_queue_seq_ctrl #(
   parameter int ADDR_W = 10,
   parameter int NTAPS  = 1021
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wrt_smpl,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [ADDR_W-1:0] raddr,
   output logic [ADDR_W-1:0] coeff_addr,
   output logic              sequencing,
   output logic              acc_clr,
   output logic              mac_en,
   output logic              seq_done,
   output logic              full,
   output logic              overrun
);

`ifdef RD_LAT2_EN
   localparam int RD_LAT = 2;
`else
   localparam int RD_LAT = 1;
`endif

   localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NTAPS - 1);
   localparam logic [ADDR_W-1:0] TAPS     = ADDR_W'(NTAPS);
   localparam logic              PH_LAST  = 1'(RD_LAT - 1);

   typedef enum logic [2:0] {IDLE, PRIME, SEQ, DRAIN, DONE} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   new_ptr_q, new_ptr_d;
   logic [ADDR_W-1:0]   old_ptr_q, old_ptr_d;
   logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;
   logic                full_q, full_d;
   logic [ADDR_W-1:0]   rd_ptr_q, end_ptr_q, coeff_q;
   logic                pend_q, overrun_q;
   logic                seq_q, acc_clr_q, done_q;
   logic                cnt_q;
   logic [RD_LAT-1:0]   mac_sr_q;
   logic                start_req;

   // A start uses the old pointer after this cycle's write, so the just-written sample is the newest tap.
   always_comb begin
      start_req  = wrt_smpl & full_q;
      new_ptr_d  = wrt_smpl ? new_ptr_q + ADDR_W'(1) : new_ptr_q;
      old_ptr_d  = start_req ? old_ptr_q + ADDR_W'(1) : old_ptr_q;
      fill_cnt_d = (wrt_smpl && fill_cnt_q != TAPS) ? fill_cnt_q + ADDR_W'(1) : fill_cnt_q;
      full_d     = full_q | (wrt_smpl && fill_cnt_q == LAST_TAP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         new_ptr_q  <= '0;
         old_ptr_q  <= '0;
         fill_cnt_q <= '0;
         full_q     <= 1'b0;
         rd_ptr_q   <= '0;
         end_ptr_q  <= '0;
         coeff_q    <= '0;
         pend_q     <= 1'b0;
         overrun_q  <= 1'b0;
         seq_q      <= 1'b0;
         acc_clr_q  <= 1'b0;
         done_q     <= 1'b0;
         cnt_q      <= 1'b0;
         mac_sr_q   <= '0;
      end else begin
         new_ptr_q  <= new_ptr_d;
         old_ptr_q  <= old_ptr_d;
         fill_cnt_q <= fill_cnt_d;
         full_q     <= full_d;
         acc_clr_q  <= 1'b0;
         done_q     <= 1'b0;
         mac_sr_q   <= RD_LAT'({mac_sr_q, seq_q});

         // Only one extra pass can be queued; DONE below consumes the queued one on the same edge.
         if (start_req && state_q != IDLE) begin
            if (pend_q)
               overrun_q <= 1'b1;
            else
               pend_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (start_req) begin
                  rd_ptr_q  <= old_ptr_d;
                  end_ptr_q <= old_ptr_d + LAST_TAP;
                  coeff_q   <= '0;
                  cnt_q     <= 1'b0;
                  acc_clr_q <= (PH_LAST == 1'b0);
                  state_q   <= PRIME;
               end
            end
            PRIME: begin
               if (cnt_q == PH_LAST) begin
                  seq_q   <= 1'b1;
                  state_q <= SEQ;
               end else begin
                  cnt_q     <= cnt_q + 1'b1;
                  acc_clr_q <= ((cnt_q + 1'b1) == PH_LAST);
               end
            end
            SEQ: begin
               if (rd_ptr_q == end_ptr_q) begin
                  seq_q   <= 1'b0;
                  cnt_q   <= 1'b0;
                  state_q <= DRAIN;
               end else begin
                  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                  coeff_q  <= coeff_q + ADDR_W'(1);
               end
            end
            DRAIN: begin
               if (cnt_q == PH_LAST) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (pend_q || start_req) begin
                  pend_q    <= 1'b0;
                  rd_ptr_q  <= old_ptr_d;
                  end_ptr_q <= old_ptr_d + LAST_TAP;
                  coeff_q   <= '0;
                  cnt_q     <= 1'b0;
                  acc_clr_q <= (PH_LAST == 1'b0);
                  state_q   <= PRIME;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign we         = wrt_smpl;
   assign waddr      = new_ptr_q;
   assign raddr      = rd_ptr_q;
   assign coeff_addr = coeff_q;
   assign sequencing = seq_q;
   assign acc_clr    = acc_clr_q;
   assign mac_en     = mac_sr_q[RD_LAT-1];
   assign seq_done   = done_q;
   assign full       = full_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_eq_queue_seq_ctrl.sv
// Self-checking bench for eq_queue_seq_ctrl: directed scenarios then random strobes,
// compared against a pass-timeline model of the queue.
module tb_eq_queue_seq_ctrl;

   localparam int ADDR_W = 3;
   localparam int N      = 5;
   localparam int D      = 1 << ADDR_W;
`ifdef RD_LAT2_EN
   localparam int RD = 2;
`else
   localparam int RD = 1;
`endif
   localparam int L = 2 * RD + N + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              wrt_smpl;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W-1:0] raddr;
   logic [ADDR_W-1:0] coeff_addr;
   logic              sequencing;
   logic              acc_clr;
   logic              mac_en;
   logic              seq_done;
   logic              full;
   logic              overrun;

   int checks   = 0;
   int failures = 0;

   // Model: a pass is a timeline of L cycles counted from its launch edge.
   int mNew, mFill, mK, mBase, mRd, mCoeff;
   bit mActive, mPend, mOver;

   eq_queue_seq_ctrl #(.ADDR_W(ADDR_W), .NTAPS(N)) dut (
      .clk(clk), .rst(rst), .wrt_smpl(wrt_smpl), .we(we), .waddr(waddr),
      .raddr(raddr), .coeff_addr(coeff_addr), .sequencing(sequencing),
      .acc_clr(acc_clr), .mac_en(mac_en), .seq_done(seq_done),
      .full(full), .overrun(overrun)
   );

   always #5 clk = ~clk;

   function automatic int wrapAddr(input int x);
      return ((x % D) + D) % D;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic checkOutput(input bit w);
      int j;
      if (mActive) begin
         j = mK - RD - 1;
         if (j < 0) j = 0;
         if (j > N - 1) j = N - 1;
         mRd    = wrapAddr(mBase + j);
         mCoeff = j;
      end
      chk("we",         32'(we),         32'(w));
      chk("waddr",      32'(waddr),      32'(mNew));
      chk("raddr",      32'(raddr),      32'(mRd));
      chk("coeff_addr", 32'(coeff_addr), 32'(mCoeff));
      chk("sequencing", 32'(sequencing), 32'(mActive && mK > RD && mK <= RD + N));
      chk("acc_clr",    32'(acc_clr),    32'(mActive && mK == RD));
      chk("mac_en",     32'(mac_en),     32'(mActive && mK > 2 * RD && mK <= 2 * RD + N));
      chk("seq_done",   32'(seq_done),   32'(mActive && mK == L));
      chk("full",       32'(full),       32'(mFill == N));
      chk("overrun",    32'(overrun),    32'(mOver));
   endtask

   task automatic modelEdge(input bit w, input bit r);
      bit start;
      int base;
      if (r) begin
         mNew = 0; mFill = 0; mK = 0; mBase = 0; mRd = 0; mCoeff = 0;
         mActive = 0; mPend = 0; mOver = 0;
         return;
      end
      start = w && (mFill == N);
      base  = wrapAddr(mNew + (w ? 1 : 0) - N);
      if (!mActive) begin
         if (start) begin
            mActive = 1; mK = 1; mBase = base;
         end
      end else if (mK == L) begin
         if (start && mPend) mOver = 1;
         if (start || mPend) begin
            mK = 1; mBase = base; mPend = 0;
         end else begin
            mActive = 0;
         end
      end else begin
         mK++;
         if (start) begin
            if (mPend) mOver = 1;
            else mPend = 1;
         end
      end
      if (w) begin
         mNew = wrapAddr(mNew + 1);
         if (mFill < N) mFill++;
      end
   endtask

   task automatic applyStimulus(input bit w, input bit r);
      @(negedge clk);
      wrt_smpl = w;
      rst      = r;
      #1;
      checkOutput(w);
      @(posedge clk);
      modelEdge(w, r);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      wrt_smpl = 1'b0;
      modelEdge(1'b0, 1'b1);
      @(posedge clk);
      applyStimulus(1'b0, 1'b1);

      // Fill below threshold: no pass may start
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0);
         applyStimulus(1'b0, 1'b0);
      end

      // Fifth write sets full, sixth launches the first pass
      applyStimulus(1'b1, 1'b0);
      idle(2);
      applyStimulus(1'b1, 1'b0);
      idle(L + 4);

      // Writes across the pointer wrap, each launching a pass
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0);
         idle(L + 4);
      end

      // Two extra starts inside one pass: pend then overrun
      applyStimulus(1'b1, 1'b0);
      idle(2);
      applyStimulus(1'b1, 1'b0);
      idle(2);
      applyStimulus(1'b1, 1'b0);
      idle(3 * L);

      // Start landing exactly on the DONE cycle
      applyStimulus(1'b1, 1'b0);
      idle(L - 1);
      applyStimulus(1'b1, 1'b0);
      idle(2 * L);

      // Reset in the middle of a pass
      applyStimulus(1'b1, 1'b0);
      idle(RD + 2);
      applyStimulus(1'b0, 1'b1);
      idle(3);

      for (int i = 0; i < 800; i++) begin
         applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
